line_rasterizer: RTL and testbench
==================================

LINE_RASTERIZER -- requirements
Module: line_rasterizer

Interface
REQ-001 Parameter H_RES, default 640, meaning framebuffer width in pixels and the row stride for addresses.
REQ-002 Parameter V_RES, default 480, meaning framebuffer height in pixels.
REQ-003 clk  input  1  clock; all state advances on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request to draw one line; sampled in IDLE only.
REQ-006 x0, x1  input  10  line endpoint X coordinates, unsigned.
REQ-007 y0, y1  input  9  line endpoint Y coordinates, unsigned.
REQ-008 color_in  input  4  line colour; latched when start is accepted.
REQ-009 frame_end  input  1  vector list complete; request a framebuffer swap.
REQ-010 ready  input  1  framebuffer controller has swapped buffers and accepts writes.
REQ-011 w_addr  output  19  pixel write address, computed as y*H_RES+x.
REQ-012 color  output  4  pixel write colour.
REQ-013 en_w  output  1  pixel write strobe.
REQ-014 done  output  1  one-cycle frame-complete pulse to the framebuffer controller.
REQ-015 busy  output  1  high whenever the block is not in IDLE.
REQ-016 line_done  output  1  one-cycle pulse on the last pixel cycle of a line.

Function
REQ-017 The FSM SHALL have four states: IDLE, SETUP, DRAW and WAIT_RDY.
REQ-018 IDLE with start=1: latch endpoints and colour, go to SETUP; start SHALL take priority over a simultaneous frame_end.
REQ-019 IDLE with start=0 and frame_end=1: pulse done for one cycle, go to WAIT_RDY.
REQ-020 WAIT_RDY: return to IDLE on ready=1; start and frame_end SHALL be ignored while in WAIT_RDY.
REQ-021 SETUP SHALL compute:
- dx=|x1-x0|, dy=-|y1-y0|;
- sx, sy = +1/-1 according to endpoint order;
- err=dx+dy, signed 12-bit;
- current point (x,y)=(x0,y0).
REQ-022 DRAW SHALL emit one pixel per cycle at the current (x,y), following Bresenham:
- e2=2*err;
- if e2>=dy: err+=dy and x+=sx;
- if e2<=dx: err+=dx and y+=sy;
- both updates apply in the same cycle when both conditions hold.
REQ-023 In DRAW, when (x,y)==(x1,y1), line_done SHALL pulse and the next state SHALL be IDLE.
REQ-024 Pixel count per line SHALL be max(dx,|dy|)+1; a zero-length line yields exactly one pixel.
REQ-025 Latency: start accepted in cycle N gives SETUP in N+1, first pixel in N+2, and busy=0 in the cycle after the last pixel.
REQ-026 en_w SHALL be 1 only in DRAW with x<H_RES and y<V_RES.
- Off-screen pixels still consume a cycle but are not written (clip).
REQ-027 w_addr and color SHALL be valid whenever en_w=1; their values are don't-care otherwise.
REQ-028 Internal X/Y arithmetic SHALL be 11-bit signed, so that stepping never wraps at 0 or 1023.
REQ-029 start asserted while busy SHALL be ignored; the source holds start until busy falls.

Reset
REQ-030 rst SHALL force IDLE with en_w=0, done=0, line_done=0, busy=0, w_addr=0 and color=0.
REQ-031 rst asserted mid-line or in WAIT_RDY SHALL abandon the operation with no further writes after release.

Structure
REQ-032 H_RES, V_RES, coordinate widths, the address width (19) and the state enum SHALL reside in the shared package fb_pkg.
REQ-033 The y*H_RES+x address calculation SHALL be a sub-module, fb_addr_gen, reusable by other framebuffer writers.

Verification
REQ-034 Horizontal line (0,0)-(3,0): writes at addresses 0,1,2,3 on cycles N+2..N+5; line_done pulses on cycle N+5.
REQ-035 Vertical line (5,2)-(5,4): writes at 1285, 1925, 2565; reversed diagonal (3,3)-(0,0): writes at 1923, 1282, 641, 0.
REQ-036 Single point (639,479) with color_in=4'hA: exactly one write at 307199 with colour 4'hA.
REQ-037 Clipped line (638,0)-(641,0): four DRAW cycles, with en_w=1 only for addresses 638 and 639.
REQ-038 frame_end=1 and start=1 together in IDLE: the line draws first, then done pulses; a start asserted during WAIT_RDY produces no write until ready=1.
REQ-039 rst asserted on the third pixel of (0,0)-(9,0): en_w=0 from the reset edge onward, and busy=0 after release.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared framebuffer definitions: geometry defaults, coordinate/address widths
// and the line-rasterizer state encoding.
package fb_pkg;
  localparam int FB_H_RES = 640;
  localparam int FB_V_RES = 480;
  localparam int X_W      = 10;
  localparam int Y_W      = 9;
  localparam int ADDR_W   = 19;
  localparam int COLOR_W  = 4;
  localparam int COORD_W  = 11;  // signed working width for x/y stepping
  localparam int ERR_W    = 12;  // signed Bresenham error width

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETUP    = 2'd1,
    DRAW     = 2'd2,
    WAIT_RDY = 2'd3
  } state_t;
endpackage

// File: rtl/fb_addr_gen.sv
// Linear framebuffer address: addr = y*H_RES + x. Shared by framebuffer writers.
module fb_addr_gen
  import fb_pkg::*;
#(
  parameter int H_RES = FB_H_RES
) (
  input  logic [X_W-1:0]    x,
  input  logic [Y_W-1:0]    y,
  output logic [ADDR_W-1:0] addr
);

  logic [31:0] full_addr;

  assign full_addr = 32'(y) * 32'(H_RES) + 32'(x);
  assign addr      = full_addr[ADDR_W-1:0];

endmodule

// File: rtl/line_rasterizer.sv
// Bresenham line rasterizer: one pixel per cycle into a framebuffer, with
// on-screen clipping and a frame_end/ready buffer-swap handshake.
module line_rasterizer
  import fb_pkg::*;
#(
  parameter int H_RES = FB_H_RES,
  parameter int V_RES = FB_V_RES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [X_W-1:0]     x0,
  input  logic [X_W-1:0]     x1,
  input  logic [Y_W-1:0]     y0,
  input  logic [Y_W-1:0]     y1,
  input  logic [COLOR_W-1:0] color_in,
  input  logic               frame_end,
  input  logic               ready,
  output logic [ADDR_W-1:0]  w_addr,
  output logic [COLOR_W-1:0] color,
  output logic               en_w,
  output logic               done,
  output logic               busy,
  output logic               line_done,
  output state_t             state_dbg
);

  // Handshake: start is a request sampled only in IDLE; busy rises the cycle
  // after acceptance and any start seen while busy is ignored (not queued).
  // frame_end in IDLE (without start) raises done for one cycle; the block
  // then stays busy in WAIT_RDY until the controller answers with ready.

  localparam logic signed [COORD_W-1:0] ONE = COORD_W'(1);

  state_t state, state_nxt;

  logic signed [COORD_W-1:0] x_r, y_r, x_end, y_end;
  logic signed [COORD_W-1:0] x_nxt, y_nxt;
  logic signed [COORD_W-1:0] ddx, ddy, adx, ady;
  logic signed [ERR_W-1:0]   dx_r, dy_r, err_r, err_nxt;
  logic signed [ERR_W:0]     e2, dx_e, dy_e;
  logic                      sx_neg, sy_neg;
  logic                      step_x, step_y, at_end, on_x, on_y;
  logic [COLOR_W-1:0]        color_r;
  logic                      done_q;

  // Endpoint deltas, used only in SETUP when x_r/y_r still hold (x0,y0).
  assign ddx = x_end - x_r;
  assign ddy = y_end - y_r;
  assign adx = ddx[COORD_W-1] ? -ddx : ddx;
  assign ady = ddy[COORD_W-1] ? -ddy : ddy;

  assign e2     = {err_r, 1'b0};
  assign dx_e   = {dx_r[ERR_W-1], dx_r};
  assign dy_e   = {dy_r[ERR_W-1], dy_r};
  assign step_x = (e2 >= dy_e);
  assign step_y = (e2 <= dx_e);
  assign at_end = (x_r == x_end) && (y_r == y_end);

  always_comb begin
    err_nxt = err_r;
    x_nxt   = x_r;
    y_nxt   = y_r;
    if (step_x) begin
      err_nxt = err_nxt + dy_r;
      x_nxt   = sx_neg ? x_r - ONE : x_r + ONE;
    end
    if (step_y) begin
      err_nxt = err_nxt + dx_r;
      y_nxt   = sy_neg ? y_r - ONE : y_r + ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    line_done = 1'b0;
    case (state)
      IDLE: begin
        if (start)          state_nxt = SETUP;
        else if (frame_end) state_nxt = WAIT_RDY;
      end
      SETUP: state_nxt = DRAW;
      DRAW: begin
        if (at_end) begin
          line_done = 1'b1;
          state_nxt = IDLE;
        end
      end
      WAIT_RDY: begin
        if (ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_r     <= '0;
      y_r     <= '0;
      x_end   <= '0;
      y_end   <= '0;
      dx_r    <= '0;
      dy_r    <= '0;
      err_r   <= '0;
      sx_neg  <= 1'b0;
      sy_neg  <= 1'b0;
      color_r <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= (state == IDLE) && !start && frame_end;
      case (state)
        IDLE: begin
          if (start) begin
            x_r     <= {1'b0, x0};
            y_r     <= {2'b00, y0};
            x_end   <= {1'b0, x1};
            y_end   <= {2'b00, y1};
            color_r <= color_in;
          end
        end
        SETUP: begin
          dx_r   <= {adx[COORD_W-1], adx};
          dy_r   <= -{ady[COORD_W-1], ady};
          err_r  <= {adx[COORD_W-1], adx} - {ady[COORD_W-1], ady};
          sx_neg <= ddx[COORD_W-1];
          sy_neg <= ddy[COORD_W-1];
        end
        DRAW: begin
          if (!at_end) begin
            x_r   <= x_nxt;
            y_r   <= y_nxt;
            err_r <= err_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  // Clip: pixels outside the visible frame still take their DRAW cycle.
  assign on_x = !x_r[COORD_W-1] && (int'(x_r[COORD_W-2:0]) < H_RES);
  assign on_y = !y_r[COORD_W-1] && (int'(y_r[COORD_W-2:0]) < V_RES);

  fb_addr_gen #(.H_RES(H_RES)) u_addr_gen (
    .x    (x_r[X_W-1:0]),
    .y    (y_r[Y_W-1:0]),
    .addr (w_addr)
  );

  assign en_w      = (state == DRAW) && on_x && on_y;
  assign color     = color_r;
  assign done      = done_q;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_line_rasterizer.sv
// Directed self-checking bench for line_rasterizer: hand-computed pixel
// addresses, latency, clipping, frame handshake and reset abort.
module tb_line_rasterizer;
  import fb_pkg::*;

  logic               clk, rst, start, frame_end, ready;
  logic [X_W-1:0]     x0, x1;
  logic [Y_W-1:0]     y0, y1;
  logic [COLOR_W-1:0] color_in;
  logic [ADDR_W-1:0]  w_addr;
  logic [COLOR_W-1:0] color;
  logic               en_w, done, busy, line_done;
  state_t             state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [ADDR_W-1:0]  exp_q[$];
  logic [ADDR_W-1:0]  got_q[$];
  logic [COLOR_W-1:0] got_c[$];
  int first_wr, ld_at, ld_cnt, done_cnt, draw_cyc;
  logic timed_out;

  line_rasterizer #(.H_RES(640), .V_RES(480)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .x0        (x0),
    .x1        (x1),
    .y0        (y0),
    .y1        (y1),
    .color_in  (color_in),
    .frame_end (frame_end),
    .ready     (ready),
    .w_addr    (w_addr),
    .color     (color),
    .en_w      (en_w),
    .done      (done),
    .busy      (busy),
    .line_done (line_done),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // driver: request a line in cycle N, return at the SETUP cycle N+1
  task automatic start_line(input int ax0, input int ay0, input int ax1, input int ay1,
                            input logic [3:0] col);
    @(negedge clk);
    x0 = X_W'(ax0); y0 = Y_W'(ay0); x1 = X_W'(ax1); y1 = Y_W'(ay1);
    color_in = col;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("setup_state", 32'(state_dbg), 32'(SETUP));
    chk("setup_no_write", 32'(en_w), 32'd0);
  endtask

  // monitor: k=0 is cycle N+2; draw_cyc = cycles until busy falls
  task automatic collect();
    got_q = {}; got_c = {};
    first_wr = -1; ld_at = -1; ld_cnt = 0; done_cnt = 0; draw_cyc = -1;
    timed_out = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (!busy) begin
        draw_cyc  = k;
        timed_out = 1'b0;
        break;
      end
      if (en_w) begin
        got_q.push_back(w_addr);
        got_c.push_back(color);
        if (first_wr < 0) first_wr = k;
      end
      if (line_done) begin
        ld_cnt++;
        ld_at = k;
      end
      if (done) done_cnt++;
    end
    chk("line_timeout", 32'(timed_out), 32'd0);
  endtask

  // scoreboard: compare collected writes against exp_q
  task automatic check_line(input string tag, input logic [3:0] col);
    chk({tag, "_nwrites"}, 32'(got_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (i < got_q.size()) begin
        chk($sformatf("%s_addr%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        chk($sformatf("%s_col%0d", tag, i), 32'(got_c[i]), 32'(col));
      end
    end
    chk({tag, "_ld_cnt"}, 32'(ld_cnt), 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; frame_end = 1'b0; ready = 1'b0;
    x0 = '0; x1 = '0; y0 = '0; y1 = '0; color_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_en_w", 32'(en_w), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_line_done", 32'(line_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_w_addr", 32'(w_addr), 32'd0);
    chk("rst_color", 32'(color), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'(IDLE));
    rst = 1'b0;

    // horizontal (0,0)-(3,0)
    start_line(0, 0, 3, 0, 4'h3);
    collect();
    exp_q = '{19'd0, 19'd1, 19'd2, 19'd3};
    check_line("horiz", 4'h3);
    chk("horiz_first_wr", 32'(first_wr), 32'd0);
    chk("horiz_ld_at", 32'(ld_at), 32'd3);
    chk("horiz_busy_fall", 32'(draw_cyc), 32'd4);

    // vertical (5,2)-(5,4)
    start_line(5, 2, 5, 4, 4'h5);
    collect();
    exp_q = '{19'd1285, 19'd1925, 19'd2565};
    check_line("vert", 4'h5);
    chk("vert_cycles", 32'(draw_cyc), 32'd3);

    // reversed diagonal (3,3)-(0,0)
    start_line(3, 3, 0, 0, 4'h7);
    collect();
    exp_q = '{19'd1923, 19'd1282, 19'd641, 19'd0};
    check_line("diag", 4'h7);

    // shallow slope (0,0)-(4,2): pixels (0,0),(1,1),(2,1),(3,2),(4,2)
    start_line(0, 0, 4, 2, 4'h9);
    collect();
    exp_q = '{19'd0, 19'd641, 19'd642, 19'd1283, 19'd1284};
    check_line("slope", 4'h9);
    chk("slope_cycles", 32'(draw_cyc), 32'd5);

    // single point at the bottom-right corner
    start_line(639, 479, 639, 479, 4'hA);
    collect();
    exp_q = '{19'd307199};
    check_line("point", 4'hA);
    chk("point_cycles", 32'(draw_cyc), 32'd1);

    // clipped (638,0)-(641,0): four DRAW cycles, two writes
    start_line(638, 0, 641, 0, 4'hC);
    collect();
    exp_q = '{19'd638, 19'd639};
    check_line("clip", 4'hC);
    chk("clip_cycles", 32'(draw_cyc), 32'd4);
    chk("clip_ld_at", 32'(ld_at), 32'd3);

    // start and frame_end together: line first, then done
    @(negedge clk);
    x0 = 10'd1; y0 = 9'd1; x1 = 10'd2; y1 = 9'd1; color_in = 4'h2;
    start = 1'b1; frame_end = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("fe_prio_state", 32'(state_dbg), 32'(SETUP));
    collect();
    exp_q = '{19'd641, 19'd642};
    check_line("fe_line", 4'h2);
    chk("fe_no_done_in_line", 32'(done_cnt), 32'd0);
    chk("fe_idle_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("fe_wait_state", 32'(state_dbg), 32'(WAIT_RDY));
    chk("fe_done_pulse", 32'(done), 32'd1);
    frame_end = 1'b0;
    x0 = 10'd7; y0 = 9'd0; x1 = 10'd7; y1 = 9'd0; color_in = 4'h6;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("wait_done_%0d", i), 32'(done), 32'd0);
      chk($sformatf("wait_no_write_%0d", i), 32'(en_w), 32'd0);
      chk($sformatf("wait_state_%0d", i), 32'(state_dbg), 32'(WAIT_RDY));
    end
    ready = 1'b1;
    @(negedge clk);
    chk("ready_idle", 32'(busy), 32'd0);
    ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("after_ready_setup", 32'(state_dbg), 32'(SETUP));
    collect();
    exp_q = '{19'd7};
    check_line("after_ready", 4'h6);

    // reset on the third pixel of (0,0)-(9,0)
    start_line(0, 0, 9, 0, 4'hF);
    repeat (3) @(negedge clk);
    chk("rst_mid_en_w_pre", 32'(en_w), 32'd1);
    chk("rst_mid_addr_pre", 32'(w_addr), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_en_w", 32'(en_w), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("post_rst_busy_%0d", i), 32'(busy), 32'd0);
      chk($sformatf("post_rst_en_w_%0d", i), 32'(en_w), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
